// File: rtl/piso_serial_tx_pkg.sv
// Shared definitions for the serial transmit path and the receive-side blocks
// that decode the same state encodings.
package piso_serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } tx_state_t;

    // Number of serial bits carried by one transfer: data bits plus optional parity.
    function automatic int bits_per_xfer(input int width, input int parity_en);
        return width + ((parity_en != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/piso_serial_tx_bit_counter.sv
// Transmit bit counter: counts serial bits sent in the current transfer and
// flags the last one so the FSM can leave SHIFT on the following edge.
module piso_serial_tx_bit_counter
    import piso_serial_tx_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Count register: clear has priority over enable so a new transfer always starts from zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter. A word is captured on an accepted start,
// shifted out one bit per clock with a qualifying enable, optionally followed by
// an even-parity bit, and the transfer ends with a one-cycle done pulse.
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             busy,
    output logic             sd,
    output logic             se,
    output logic             done
);

    localparam int N  = bits_per_xfer(WIDTH, PARITY_EN);
    localparam int CW = $clog2(N + 1);

    // Counter value at which the parity bit is presented instead of a data bit.
    localparam logic [CW-1:0] PAR_IDX = CW'(WIDTH);

    tx_state_t        state;
    tx_state_t        state_next;
    logic [WIDTH-1:0] shift_q;
    logic             parity_q;
    logic [CW-1:0]    count;
    logic             tc;
    logic             cur_bit;

    piso_serial_tx_bit_counter #(
        .N  (N),
        .CW (CW)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (state != SHIFT),
        .en    (state == SHIFT),
        .count (count),
        .tc    (tc)
    );

    // State register; reset aborts any transfer in progress without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE, and stray encodings recover to IDLE.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = start ? SHIFT : IDLE;
            SHIFT:   state_next = tc ? DONE : SHIFT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift register and parity: loaded on an accepted start, then shifted toward the output end each SHIFT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '0;
            parity_q <= 1'b0;
        end else if ((state == IDLE) && start) begin
            shift_q  <= data_in;
            parity_q <= ^data_in;
        end else if (state == SHIFT) begin
            if (MSB_FIRST != 0) begin
                shift_q <= {shift_q[WIDTH-2:0], 1'b0};
            end else begin
                shift_q <= {1'b0, shift_q[WIDTH-1:1]};
            end
        end
    end

    assign cur_bit = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];

    // Outputs decoded purely from registered state so start/data_in never reach them combinationally.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        sd    = 1'b0;
        se    = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
                busy = 1'b1;
                se   = 1'b1;
                if ((PARITY_EN != 0) && (count == PAR_IDX)) begin
                    sd = parity_q;
                end else begin
                    sd = cur_bit;
                end
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Scoreboard bench for piso_serial_tx: three instances cover MSB-first,
// LSB-first and MSB-first with parity. Stimulus pushes the hand-computed
// serial sequence; a negedge monitor pops and compares whenever se or done is up.
module tb_piso_serial_tx;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] start;
    logic [7:0] din [3];
    logic [2:0] ready;
    logic [2:0] busy;
    logic [2:0] sd;
    logic [2:0] se;
    logic [2:0] done;

    typedef struct {
        int dut;
        bit is_done;
        bit val;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) u_msb (
        .clk(clk), .reset(rst[0]), .start(start[0]), .data_in(din[0]),
        .ready(ready[0]), .busy(busy[0]), .sd(sd[0]), .se(se[0]), .done(done[0])
    );

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) u_lsb (
        .clk(clk), .reset(rst[1]), .start(start[1]), .data_in(din[1]),
        .ready(ready[1]), .busy(busy[1]), .sd(sd[1]), .se(se[1]), .done(done[1])
    );

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) u_par (
        .clk(clk), .reset(rst[2]), .start(start[2]), .data_in(din[2]),
        .ready(ready[2]), .busy(busy[2]), .sd(sd[2]), .se(se[2]), .done(done[2])
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected sequence: bits[n-1] is the first bit on the wire, then a done marker.
    task automatic pushExpected(input int d, input logic [8:0] bits, input int n);
        exp_t x;
        for (int i = n - 1; i >= 0; i--) begin
            x.dut     = d;
            x.is_done = 1'b0;
            x.val     = bits[i];
            sbq.push_back(x);
        end
        x.dut     = d;
        x.is_done = 1'b1;
        x.val     = 1'b0;
        sbq.push_back(x);
    endtask

    // One full transfer on an idle instance, with latency checks around it.
    task automatic applyStimulus(input int d, input logic [7:0] v, input logic [8:0] exp_bits, input int n);
        din[d]   = v;
        start[d] = 1'b1;
        pushExpected(d, exp_bits, n);
        tick(1);
        start[d] = 1'b0;
        din[d]   = ~v;
        checkOutput($sformatf("first_bit_status_dut%0d", d), 32'({ready[d], busy[d], se[d]}), 32'h3);
        tick(n);
        checkOutput($sformatf("done_cycle_dut%0d", d), 32'({ready[d], busy[d], se[d], done[d]}), 32'h5);
        tick(1);
        checkOutput($sformatf("ready_after_done_dut%0d", d), 32'({ready[d], busy[d], done[d]}), 32'h4);
    endtask

    // Monitor: every cycle carrying a bit or a done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (se[d] || done[d]) begin
                if (sbq.size() == 0) begin
                    checkOutput($sformatf("unexpected_output_dut%0d", d),
                                32'({se[d], done[d], sd[d]}), 32'h0);
                end else begin
                    mon_e = sbq.pop_front();
                    checkOutput($sformatf("serial_dut%0d", d),
                                {28'(d), se[d], done[d], sd[d]},
                                {28'(mon_e.dut), ~mon_e.is_done, mon_e.is_done, mon_e.val});
                end
            end
        end
    end

    initial begin
        rst   = 3'b111;
        start = 3'b000;
        for (int d = 0; d < 3; d++) din[d] = 8'h00;
        tick(2);
        rst = 3'b000;

        for (int i = 0; i < 5; i++) begin
            for (int d = 0; d < 3; d++) begin
                checkOutput($sformatf("idle_dut%0d_cyc%0d", d, i),
                            32'({ready[d], busy[d], sd[d], se[d], done[d]}), 32'h10);
            end
            tick(1);
        end

        applyStimulus(0, 8'h0F, 9'h00F, 8);
        applyStimulus(1, 8'h0F, 9'h0F0, 8);
        applyStimulus(2, 8'h07, 9'h00F, 9);
        applyStimulus(1, 8'h12, 9'h048, 8);
        applyStimulus(2, 8'h03, 9'h006, 9);
        applyStimulus(2, 8'h80, 9'h101, 9);

        din[0]   = 8'hA5;
        start[0] = 1'b1;
        pushExpected(0, 9'h0A5, 8);
        tick(1);
        start[0] = 1'b0;
        tick(3);
        rst[0] = 1'b1;
        tick(1);
        rst[0] = 1'b0;
        sbq.delete();
        checkOutput("abort_state", 32'({ready[0], busy[0], sd[0], se[0], done[0]}), 32'h10);
        tick(3);
        checkOutput("abort_still_idle", 32'({ready[0], busy[0], sd[0], se[0], done[0]}), 32'h10);
        applyStimulus(0, 8'h3C, 9'h03C, 8);

        din[0]   = 8'hFF;
        start[0] = 1'b1;
        pushExpected(0, 9'h0FF, 8);
        tick(1);
        checkOutput("held_first_bit", 32'({ready[0], busy[0], se[0]}), 32'h3);
        tick(2);
        din[0] = 8'h00;
        pushExpected(0, 9'h000, 8);
        tick(6);
        checkOutput("held_done", 32'({ready[0], busy[0], se[0], done[0]}), 32'h5);
        tick(1);
        checkOutput("held_idle_gap", 32'({ready[0], busy[0], se[0], done[0]}), 32'h8);
        tick(1);
        checkOutput("held_second_start", 32'({ready[0], busy[0], se[0]}), 32'h3);
        start[0] = 1'b0;
        tick(2);
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(14);
        checkOutput("held_final_idle", 32'({ready[0], busy[0], se[0], done[0]}), 32'h8);

        checkOutput("scoreboard_drained", 32'(sbq.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
Parallel-in, serial-out transmitter that drives the serial data/enable inputs of the team's ffd-based receive chains.
- Latches a WIDTH-bit word on a start request.
- Shifts the word out one bit per clock, with a qualifying enable strobe and an optional even-parity bit.
- Reports completion with a one-cycle done pulse.
- Sits between control FSMs (word source) and flip-flop shift/capture registers (serial sink).

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- PARITY_EN, 0, 1 = append one even-parity bit after the data bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  transfer request; sampled only while ready=1.
- data_in  input  WIDTH  word to transmit; captured on the accepted start edge.
- ready  output  1  high only in IDLE; transmitter can accept start.
- busy  output  1  high in SHIFT and DONE.
- sd  output  1  serial data bit; 0 whenever se=0.
- se  output  1  serial enable strobe; high exactly on cycles carrying a valid bit.
- done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, shift register=0, bit counter=0. Outputs: ready=1, busy=0, sd=0, se=0, done=0. Takes effect at the next rising edge.
- Reset mid-transfer: abort at the next edge. No done pulse; remaining bits are discarded.
- N = WIDTH + PARITY_EN bits per transfer. Bit counter width is clog2(N+1).
- IDLE:
  - ready=1, se=0.
  - On an edge with start=1: load data_in into the shift register, compute parity = XOR of data_in, clear the counter, go to SHIFT.
  - start=0 keeps the block in IDLE.
- SHIFT:
  - se=1 every cycle. sd = current bit: MSB or LSB of the shift register per MSB_FIRST, or the parity bit when counter=WIDTH.
  - At each edge: shift the register by one position and increment the counter.
  - When counter=N-1 at an edge, go to DONE.
  - Exactly N consecutive se-high cycles; no gaps.
- DONE: done=1, se=0, sd=0, busy=1. Next edge unconditionally returns to IDLE.
- Latency: start accepted at edge t. Bit 0 of the sequence is on the outputs during cycle t+1, the last bit during cycle t+N, done during cycle t+N+1, ready=1 during cycle t+N+2.
- start while busy: ignored, not queued.
- data_in changes after acceptance: no effect on the current transfer.
- start held high continuously: a new transfer is accepted at the first IDLE edge. Minimum gap is one IDLE cycle, plus one DONE cycle, between transfers.
- Parity: even, i.e. the total count of ones over data bits plus parity bit is even.
- Unused state encodings: go to IDLE at the next edge.
- No combinational path from start or data_in to any output. All outputs are decoded from registered state only.

Decomposition:
- Shared include file holds the state encodings as localparams: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10. Receive-side blocks reuse the same encodings.
- One sub-module is natural: tx_bit_counter.
  - Synchronous clear, enable, and a terminal-count output at N-1.
  - Built on the team's flip-flop primitive style.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset then idle, start=0 for 5 cycles -> ready=1, busy=0, se=0, sd=0, done=0 throughout.
- MSB_FIRST=1, data_in=8'h0F, start pulse at edge t -> se high cycles t+1..t+8, sd=0,0,0,0,1,1,1,1; done=1 at t+9 only; ready=1 at t+10.
- MSB_FIRST=0, data_in=8'h0F -> sd=1,1,1,1,0,0,0,0 over 8 se-high cycles; then done pulse.
- PARITY_EN=1, data_in=8'h07, MSB first -> 9 se-high cycles, sd=0,0,0,0,0,1,1,1,1 (parity=1); done on the 10th cycle.
- Transfer of 8'hA5 with reset=1 asserted during the 4th se-high cycle -> next cycle ready=1, se=0, sd=0, done never pulses. A following start with 8'h3C transmits 0,0,1,1,1,1,0,0 cleanly.
- start held high with data_in=8'hFF, changed to 8'h00 during SHIFT -> first transfer sends eight 1s. The changed data_in has no effect on it; the second transfer begins after exactly one DONE and one IDLE cycle and sends eight 0s. An extra start pulse during SHIFT is ignored: no third transfer.
